// File: rtl/pa_f_spsram_pkg.sv
// Shared definitions for the parametrised single-port SRAM with clear-after-reset.
package pa_f_spsram_pkg;

  // Controller states; IDLE is only reachable through a corrupted encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_INIT  = 2'b01,
    ST_READY = 2'b10
  } spsram_state_e;

  // Read latency seen on Q for a given output-register setting.
  function automatic int unsigned rd_latency(input int unsigned out_reg);
    if (out_reg != 32'd0) begin
      return 32'd2;
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/pa_f_spsram_core.sv
// Behavioural bit-masked storage array with registered read address and
// write-through read data. Contents are never reset; only the read path is.
module pa_f_spsram_core
  import pa_f_spsram_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          cap_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] bit_en_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0] raddr_q;
  logic [DW-1:0] dout_q;
  logic          valid_q;
  logic [DW-1:0] old_word_s;
  logic [DW-1:0] merged_s;

  // Merge the addressed word with the enabled data bits; a read passes it unchanged.
  always_comb begin
    old_word_s = mem_q[addr_i];
    merged_s   = old_word_s;
    if (we_i) begin
      merged_s = (old_word_s & ~bit_en_i) | (din_i & bit_en_i);
    end else begin
      merged_s = old_word_s;
    end
  end

  // Array write port; contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= merged_s;
    end
  end

  // Read path: capture address on access, otherwise keep presenting the held
  // location. Until the first access after reset the output is forced to zero
  // so an uninitialised array never leaks X onto Q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raddr_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else if (cap_i) begin
      raddr_q <= addr_i;
      dout_q  <= merged_s;
      valid_q <= 1'b1;
    end else if (valid_q) begin
      dout_q  <= mem_q[raddr_q];
    end else begin
      dout_q  <= '0;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/pa_f_spsram_init.sv
// Single-port SRAM top: clear-after-reset controller, init/user port muxing
// and the optional Q pipeline register.
module pa_f_spsram_init
  import pa_f_spsram_pkg::*;
#(
  parameter int                         ADDR_WIDTH = 11,
  parameter int                         DATA_WIDTH = 32,
  parameter int                         OUT_REG    = 0,
  parameter int                         INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0]      INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY
);

  localparam int unsigned RD_LAT = rd_latency(OUT_REG);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

  spsram_state_e         state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  logic                  init_wr_s;
  logic                  user_en_s;
  logic                  core_we_s;
  logic [ADDR_WIDTH-1:0] core_addr_s;
  logic [DATA_WIDTH-1:0] core_din_s;
  logic [DATA_WIDTH-1:0] core_ben_s;
  logic [DATA_WIDTH-1:0] core_dout_s;

  // Controller: walks the init counter over every entry, then serves accesses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
      busy_q  <= (INIT_EN != 0);
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        ST_READY: begin
          busy_q <= 1'b0;
        end
        ST_IDLE: begin
          state_q <= ST_READY;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_READY;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Port mux: the init engine owns the array while clearing, user port otherwise.
  always_comb begin
    init_wr_s   = (state_q == ST_INIT) && !RST;
    user_en_s   = (state_q == ST_READY) && !CEN && !RST;
    core_we_s   = 1'b0;
    core_addr_s = A;
    core_din_s  = D;
    core_ben_s  = ~WEN;
    if (init_wr_s) begin
      core_we_s   = 1'b1;
      core_addr_s = cnt_q;
      core_din_s  = INIT_VALUE;
      core_ben_s  = {DATA_WIDTH{1'b1}};
    end else begin
      core_we_s   = user_en_s && !GWEN;
      core_addr_s = A;
      core_din_s  = D;
      core_ben_s  = ~WEN;
    end
  end

  pa_f_spsram_core #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_core (
    .clk_i    (CLK),
    .rst_i    (RST),
    .we_i     (core_we_s),
    .cap_i    (user_en_s),
    .addr_i   (core_addr_s),
    .din_i    (core_din_s),
    .bit_en_i (core_ben_s),
    .dout_o   (core_dout_s)
  );

  generate
    if (RD_LAT == 32'd2) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_pipe_q;

      // Extra output stage; keeps following the core output every cycle.
      always_ff @(posedge CLK) begin
        if (RST) begin
          q_pipe_q <= '0;
        end else begin
          q_pipe_q <= core_dout_s;
        end
      end

      assign Q = q_pipe_q;
    end else begin : g_no_out_reg
      assign Q = core_dout_s;
    end
  endgenerate

  assign INIT_BUSY = busy_q;

endmodule

// File: tb/tb_pa_f_spsram_init.sv
// Directed bench: two INIT_EN=1 instances (OUT_REG 0 and 1) share one stimulus
// stream; a third INIT_EN=0 instance has its own inputs.
module tb_pa_f_spsram_init;

  localparam logic [31:0] IV = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst, cen, gwen;
  logic [3:0]  a;
  logic [31:0] wen, d, q0, q1;
  logic        busy0, busy1;
  logic        rst2, cen2, gwen2;
  logic [3:0]  a2;
  logic [31:0] wen2, d2, q2;
  logic        busy2;

  int compared   = 0;
  int mismatched = 0;
  int n;

  always #5 clk = ~clk;

  pa_f_spsram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0), .INIT_EN(1), .INIT_VALUE(IV))
    dut0 (.CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d), .Q(q0), .INIT_BUSY(busy0));
  pa_f_spsram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(1), .INIT_EN(1), .INIT_VALUE(IV))
    dut1 (.CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d), .Q(q1), .INIT_BUSY(busy1));
  pa_f_spsram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0), .INIT_EN(0), .INIT_VALUE(IV))
    dut2 (.CLK(clk), .RST(rst2), .A(a2), .CEN(cen2), .GWEN(gwen2), .WEN(wen2), .D(d2), .Q(q2), .INIT_BUSY(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; gwen = 1'b1; a = 4'd0; wen = 32'hFFFF_FFFF; d = 32'd0;
    rst2 = 1'b1; cen2 = 1'b1; gwen2 = 1'b1; a2 = 4'd0; wen2 = 32'hFFFF_FFFF; d2 = 32'd0;

    // Reset state
    tick();
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd1);
    check("rst_q0", q0, 32'd0);
    check("rst_q1", q1, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    check("rst_q2", q2, 32'd0);

    // Init duration: exactly 16 cycles after release
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
      if (busy0) check("init_q0_zero", q0, 32'd0);
    end
    check("init_cycles", n, 32'd16);
    check("init_busy1_done", {31'd0, busy1}, 32'd0);

    // Read every address back-to-back
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); cen = 1'b0; gwen = 1'b1;
      tick();
      check("init_rd_q0", q0, IV);
      if (i > 0) check("init_rd_q1", q1, IV);
    end
    cen = 1'b1;
    tick();
    check("init_rd_q1_last", q1, IV);

    // Full write A=3 with write-through
    a = 4'd3; cen = 1'b0; gwen = 1'b0; wen = 32'h0000_0000; d = 32'hDEAD_BEEF;
    tick();
    check("wr_q0", q0, 32'hDEAD_BEEF);
    check("wr_q1_lat", q1, IV);
    gwen = 1'b1; wen = 32'hFFFF_FFFF; d = 32'd0;
    tick();
    check("rd_q0", q0, 32'hDEAD_BEEF);
    check("rd_q1", q1, 32'hDEAD_BEEF);

    // Partial mask write
    gwen = 1'b0; wen = 32'hFFFF_0000; d = 32'h1234_5678;
    tick();
    check("pwr_q0", q0, 32'hDEAD_5678);
    check("pwr_q1_lat", q1, 32'hDEAD_BEEF);
    gwen = 1'b1; wen = 32'hFFFF_FFFF; d = 32'd0;
    tick();
    check("prd_q0", q0, 32'hDEAD_5678);
    check("prd_q1", q1, 32'hDEAD_5678);

    // Idle hold with toggling address and junk write controls
    cen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 4'(i * 5 + 1); gwen = 1'(i); wen = 32'h0; d = 32'h5555_0000 + 32'(i);
      tick();
      check("hold_q0", q0, 32'hDEAD_5678);
      check("hold_q1", q1, 32'hDEAD_5678);
    end

    // Write with all mask bits off behaves as a read
    a = 4'd3; cen = 1'b0; gwen = 1'b0; wen = 32'hFFFF_FFFF; d = 32'h0BAD_0BAD;
    tick();
    check("nomask_q0", q0, 32'hDEAD_5678);
    gwen = 1'b1;
    tick();
    check("nomask_rd_q0", q0, 32'hDEAD_5678);
    cen = 1'b1;

    // Reset during init, with writes attempted throughout
    rst = 1'b1;
    tick();
    rst = 1'b0; a = 4'd3; cen = 1'b0; gwen = 1'b0; wen = 32'h0; d = 32'h1111_1111;
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy0", {31'd0, busy0}, 32'd1);
    check("mid_q0", q0, 32'd0);
    rst = 1'b1;
    tick();
    check("rerst_busy0", {31'd0, busy0}, 32'd1);
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
    end
    cen = 1'b1; gwen = 1'b1; wen = 32'hFFFF_FFFF;
    check("reinit_cycles", n, 32'd16);
    check("reinit_q0", q0, 32'd0);
    check("reinit_q1", q1, 32'd0);
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); cen = 1'b0;
      tick();
      check("reinit_rd_q0", q0, IV);
    end
    cen = 1'b1;

    // INIT_EN=0 instance: access on the first cycle after reset
    rst2 = 1'b0; a2 = 4'd5; cen2 = 1'b0; gwen2 = 1'b0; wen2 = 32'h0; d2 = 32'hCAFE_F00D;
    tick();
    check("ni_busy", {31'd0, busy2}, 32'd0);
    check("ni_wr_q", q2, 32'hCAFE_F00D);
    gwen2 = 1'b1; wen2 = 32'hFFFF_FFFF; d2 = 32'd0;
    tick();
    check("ni_rd_q", q2, 32'hCAFE_F00D);
    gwen2 = 1'b0; wen2 = 32'h0000_FFFF; d2 = 32'h1234_5678;
    tick();
    check("ni_pwr_q", q2, 32'h1234_F00D);
    cen2 = 1'b1; gwen2 = 1'b1; a2 = 4'd9;
    tick();
    check("ni_hold_q", q2, 32'h1234_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pa_f_spsram_init.md
Name: pa_f_spsram_init

Overview:
- Parametrised single-port synchronous SRAM model for FPGA builds.
- Next generation of the fixed-size spsram wrappers: generic depth and width, per-bit write mask, optional output pipeline register, and a hardware clear-after-reset engine.
- Used for cache tag/data arrays and TCMs that need a known initial content without a software init loop.

Parameters:
- ADDR_WIDTH, 11, address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width in bits.
- OUT_REG, 0, 1 adds a Q pipeline register; read latency becomes 2.
- INIT_EN, 1, 1 enables the post-reset clear sequence.
- INIT_VALUE, 0, DATA_WIDTH-wide word written to every entry during init.

Ports:
- CLK  input  1  clock, all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  ADDR_WIDTH  access address.
- CEN  input  1  chip enable, active low.
- GWEN  input  1  global write enable, active low; 1 = read.
- WEN  input  DATA_WIDTH  per-bit write enable, active low.
- D  input  DATA_WIDTH  write data.
- Q  output  DATA_WIDTH  read data.
- INIT_BUSY  output  1  high while the clear sequence runs; accesses are ignored.

Behaviour:
- Reset: when RST=1 at a clock edge:
  - Q and the Q pipeline register go to 0; the address-holding register goes to 0.
  - INIT_BUSY goes to 1 if INIT_EN=1, else 0.
  - Array contents are not reset by RST itself.
- FSM states, in a shared encoding: IDLE, INIT, READY.
  - RST forces INIT when INIT_EN=1, else READY.
  - INIT: an init counter starts at 0. Each cycle, array[cnt] <= INIT_VALUE and cnt increments.
  - When cnt = DEPTH-1 has been written, the next state is READY and INIT_BUSY drops in that same cycle. INIT therefore lasts exactly DEPTH cycles after reset release.
  - READY: normal access. IDLE is entered only if the encoding is corrupted, and transitions to READY.
  - RST asserted during INIT restarts the sequence at cnt=0.
- Access while INIT_BUSY=1: CEN/GWEN/WEN/D are ignored; no array write; Q stays 0.
- Read (READY, CEN=0, GWEN=1):
  - Address is captured. Q = array[A] one cycle later (OUT_REG=0) or two cycles later (OUT_REG=1).
- Write (READY, CEN=0, GWEN=0):
  - For each bit i with WEN[i]=0, array[A][i] <= D[i]; other bits are kept.
  - Write-through: on the next cycle Q shows the merged word (new bits plus retained old bits). The same OUT_REG latency applies.
  - GWEN=0 with WEN all ones: no array change; Q shows the unchanged word, i.e. it behaves as a read.
- Idle (CEN=1):
  - The address-holding register keeps the last accessed address.
  - Q continues to present array[held address], so Q is stable unless the same location was changed.
  - The output register, when present, keeps updating from that held value.
- Back-to-back accesses are supported every cycle; there are no bubbles.
- The address wraps naturally at ADDR_WIDTH; no out-of-range handling is required.
- Output X-free after reset in simulation: Q driven from reset registers or initialised array only.

Decomposition:
- Package pa_f_spsram_pkg:
  - FSM state encoding (IDLE, INIT, READY, 2 bits).
  - OUT_REG latency constant function.
- Sub-module pa_f_spsram_core:
  - Behavioural bit-masked array: one write port (addr, din, bit-enable), registered read address, read-after-write-through.
  - Top level holds the FSM, init counter, port muxing (init vs user) and the optional output register.

Test Plan:
- Reset, INIT_EN=1, ADDR_WIDTH=4, INIT_VALUE=32'hA5A5_A5A5 -> INIT_BUSY high exactly 16 cycles after RST release. Read of every address returns A5A5_A5A5.
- Write A=3, D=32'hDEAD_BEEF, WEN=0, then read A=3 -> Q=DEAD_BEEF one cycle after the read (OUT_REG=0) and two cycles after (OUT_REG=1).
- Partial mask on A=3: WEN=32'hFFFF_0000, D=32'h1234_5678 -> Q after the write = DEAD_5678. A subsequent read also returns DEAD_5678.
- Read A=3, then CEN=1 for 5 cycles with A toggling -> Q holds DEAD_5678 throughout.
- Assert RST at init cycle 7, with a write attempted during INIT -> counter restarts; INIT_BUSY high 16 more cycles; the attempted write is lost; all locations read INIT_VALUE.
- INIT_EN=0 -> INIT_BUSY stays 0. A write/read on the first cycle after reset succeeds; Q=0 until the first read completes.
